// File: rtl/market_gen_multi.sv
// Multi-symbol synthetic market feed: an enable-gated tick divider triggers a
// bounded random-walk price update per symbol (round-robin) under valid/ready.
module market_gen_multi #(
  parameter int unsigned  N_SYM       = 4,
  parameter int unsigned  PRICE_W     = 16,
  parameter int unsigned  CLK_DIV     = 100000,
  parameter int unsigned  PRICE_MIN   = 100,
  parameter int unsigned  PRICE_MAX   = 60000,
  parameter int unsigned  START_PRICE = 1000,
  parameter int unsigned  STEP_W      = 3,
  parameter logic [15:0]  SEED        = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               ready,
  output logic               valid,
  output logic [3:0]         sym_id,
  output logic [PRICE_W-1:0] price,
  output logic [15:0]        seq,
  output logic [15:0]        dropped
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned IDX_W = (N_SYM > 1) ? $clog2(N_SYM) : 1;
  localparam logic [PRICE_W:0] PMIN_X = (PRICE_W+1)'(PRICE_MIN);
  localparam logic [PRICE_W:0] PMAX_X = (PRICE_W+1)'(PRICE_MAX);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [15:0]        seq_q, seq_d;
  logic [15:0]        dropped_q, dropped_d;
  logic [3:0]         sym_q, sym_d;
  logic [PRICE_W-1:0] price_q, price_d;
  logic [PRICE_W-1:0] prices_q [N_SYM];

  logic               tick, hs;
  logic [PRICE_W:0]   p_x, step_x, sum_x;
  logic [PRICE_W-1:0] new_p;

  assign tick = en && (cnt_q == CNT_W'(CLK_DIV - 1));
  assign hs   = (state_q == HOLD) && ready;

  // Arithmetic is one bit wider than the price so p+step cannot wrap before clamping.
  always_comb begin
    p_x    = {1'b0, prices_q[ptr_q]};
    step_x = (PRICE_W+1)'(lfsr_q[STEP_W:1]) + (PRICE_W+1)'(1);
    sum_x  = p_x + step_x;
    if (lfsr_q[0])
      new_p = PRICE_W'((sum_x > PMAX_X) ? PMAX_X : sum_x);
    else
      new_p = PRICE_W'((p_x < PMIN_X + step_x) ? PMIN_X : p_x - step_x);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    ptr_d     = ptr_q;
    seq_d     = seq_q;
    dropped_d = dropped_q;
    sym_d     = sym_q;
    price_d   = price_q;

    if (en) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    if (tick && (state_q != IDLE) && (dropped_q != '1))
      dropped_d = dropped_q + 16'd1;

    case (state_q)
      IDLE: if (tick) state_d = CALC;
      CALC: begin
        state_d = HOLD;
        lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        sym_d   = 4'(ptr_q);
        price_d = new_p;
      end
      HOLD: if (ready) begin
        state_d = IDLE;
        seq_d   = seq_q + 16'd1;
        ptr_d   = (ptr_q == IDX_W'(N_SYM - 1)) ? '0 : ptr_q + IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lfsr_q    <= SEED;
      ptr_q     <= '0;
      seq_q     <= '0;
      dropped_q <= '0;
      sym_q     <= '0;
      price_q   <= '0;
      for (int unsigned i = 0; i < N_SYM; i++)
        prices_q[i] <= PRICE_W'(START_PRICE);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      ptr_q     <= ptr_d;
      seq_q     <= seq_d;
      dropped_q <= dropped_d;
      sym_q     <= sym_d;
      price_q   <= price_d;
      if (state_q == CALC) prices_q[ptr_q] <= new_p;
    end
  end

  assign valid   = (state_q == HOLD) && !hs ? 1'b1 : (state_q == HOLD);
  assign sym_id  = sym_q;
  assign price   = price_q;
  assign seq     = seq_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_market_gen_multi.sv
// Randomized bench for market_gen_multi against a transaction/cycle-count reference model.
module tb_market_gen_multi;

  localparam int unsigned N      = 3;
  localparam int unsigned DIV    = 4;
  localparam int unsigned PMIN   = 100;
  localparam int unsigned PMAX   = 140;
  localparam int unsigned PSTART = 130;
  localparam int unsigned SW     = 3;
  localparam int unsigned SEEDV  = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst, en, ready;
  logic        valid;
  logic [3:0]  sym_id;
  logic [15:0] price, seq, dropped;

  always #5 clk = ~clk;

  market_gen_multi #(
    .N_SYM(N), .PRICE_W(16), .CLK_DIV(DIV), .PRICE_MIN(PMIN), .PRICE_MAX(PMAX),
    .START_PRICE(PSTART), .STEP_W(SW), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ready(ready), .valid(valid),
    .sym_id(sym_id), .price(price), .seq(seq), .dropped(dropped)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: update pending = 0 none, 1 being computed, 2 presented.
  int unsigned m_lfsr, m_en_cycles, m_pending, m_ptr, m_seq, m_drop, m_sym, m_price;
  int unsigned m_prices[N];
  int          max_hits, min_hits;

  function automatic void model_reset();
    m_lfsr = SEEDV; m_en_cycles = 0; m_pending = 0; m_ptr = 0;
    m_seq = 0; m_drop = 0; m_sym = 0; m_price = 0;
    for (int i = 0; i < N; i++) m_prices[i] = PSTART;
  endfunction

  function automatic void model_step(input bit e, input bit r);
    bit tick;
    int unsigned step, p, np, fb;
    tick = e && (((m_en_cycles + 1) % DIV) == 0);
    if (e) m_en_cycles++;
    if (m_pending != 0 && tick && m_drop < 65535) m_drop++;
    case (m_pending)
      0: if (tick) m_pending = 1;
      1: begin
        step = ((m_lfsr >> 1) & ((1 << SW) - 1)) + 1;
        p    = m_prices[m_ptr];
        if (m_lfsr & 1) np = (p + step > PMAX) ? PMAX : p + step;
        else            np = (p < PMIN + step) ? PMIN : p - step;
        m_prices[m_ptr] = np;
        m_sym = m_ptr; m_price = np;
        fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = (m_lfsr >> 1) | (fb << 15);
        m_pending = 2;
      end
      default: if (r) begin
        m_pending = 0;
        m_seq = (m_seq + 1) & 16'hFFFF;
        m_ptr = (m_ptr + 1) % N;
      end
    endcase
  endfunction

  task automatic check_outputs();
    check("valid", valid, m_pending == 2);
    check("seq", seq, m_seq);
    check("dropped", dropped, m_drop);
    if (m_pending == 2) begin
      check("sym_id", sym_id, m_sym);
      check("price", price, m_price);
      check("price_range", (price >= PMIN) && (price <= PMAX), 1);
      if (price == PMAX) max_hits++;
      if (price == PMIN) min_hits++;
    end
  endtask

  task automatic cyc(input bit e, input bit r);
    en = e; ready = r;
    @(posedge clk);
    model_step(e, r);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic check_reset_state();
    check("rst_valid", valid, 0);
    check("rst_seq", seq, 0);
    check("rst_dropped", dropped, 0);
    check("rst_sym", sym_id, 0);
    check("rst_price", price, 0);
  endtask

  initial begin
    max_hits = 0; min_hits = 0;
    model_reset();
    rst = 1'b1; en = 1'b0; ready = 1'b0;
    #100;
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;

    // Steady stream, ready always high: one update per DIV cycles, no drops.
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b1);

    // Back-pressure: freeze outputs for 20 cycles, ticks are dropped.
    for (int i = 0; i < 20 && !valid; i++) cyc(1'b1, 1'b0);
    check("wait_valid_bp", valid, 1);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);

    // Divider frozen while disabled, then resumes from its held count.
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1);

    // Random enable/ready traffic drives prices into both bounds.
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0);

    // Asynchronous reset while an update is held.
    for (int i = 0; i < 20 && !valid; i++) cyc(1'b1, 1'b0);
    check("wait_valid_rst", valid, 1);
    rst = 1'b1;
    #1;
    check_reset_state();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1);
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 1) != 0);

    check("max_reached", max_hits > 0, 1);
    check("min_reached", min_hits > 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
